his_reader_fsm: RTL and testbench



---
 rtl/his_reader_fsm_pkg.sv | 13 +
 rtl/his_skid_fifo.sv | 37 +++
 rtl/his_reader_fsm.sv | 99 +++++++++
 tb/tb_his_reader_fsm.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/his_reader_fsm_pkg.sv
// his_reader_fsm_pkg: histogram geometry and reader FSM state encodings
// Shared by the histogram builder and the reader so both agree on
// bin address width, bin count width and the reader state values.
package his_reader_fsm_pkg;
    localparam int HIS_NB    = 8;
    localparam int HIS_CNT_W = 16;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } his_state_e;
endpackage

// File: rtl/his_skid_fifo.sv
// his_skid_fifo: two-entry FIFO with registered head
// Ports: clk, res (async active-low), push/din write side,
// pop/dout read side (dout is the head entry), full/empty status.
// Simultaneous push and pop are allowed in any non-empty state.
module his_skid_fifo #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         res,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    logic [W-1:0] mem0, mem1;
    logic [1:0]   cnt;
    assign dout  = mem0;
    assign full  = cnt == 2'd2;
    assign empty = cnt == 2'd0;
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            mem0 <= '0;
            mem1 <= '0;
            cnt  <= '0;
        end else begin
            if (pop && full)
                mem0 <= mem1;
            else if (push && (empty || pop))
                mem0 <= din;
            if (push && (full ? pop : !empty && !pop))
                mem1 <= din;
            cnt <= cnt + {1'b0, push} - {1'b0, pop};
        end
    end
endmodule

// File: rtl/his_reader_fsm.sv
// his_reader_fsm: read-and-clear histogram bank readout with peak search
// Ports: clk, res (async active-low); start/hisNum request a bank readout;
// rdEn/rdAddr/rdData read the histogram memory (data one cycle later);
// clrEn/clrAddr zero each bin as its data returns; binValid/binReady/
// binData/binAddr/binLast stream the bins; peakValid/peakAddr/peakCount
// report the maximum bin; busy is high outside IDLE.
module his_reader_fsm
    import his_reader_fsm_pkg::*;
#(
    parameter int NB    = HIS_NB,
    parameter int CNT_W = HIS_CNT_W
) (
    input  logic             clk,
    input  logic             res,
    input  logic             start,
    input  logic             hisNum,
    output logic             rdEn,
    output logic [NB:0]      rdAddr,
    input  logic [CNT_W-1:0] rdData,
    output logic             clrEn,
    output logic [NB:0]      clrAddr,
    output logic             binValid,
    input  logic             binReady,
    output logic [CNT_W-1:0] binData,
    output logic [NB-1:0]    binAddr,
    output logic             binLast,
    output logic             peakValid,
    output logic [NB-1:0]    peakAddr,
    output logic [CNT_W-1:0] peakCount,
    output logic             busy
);
    localparam int FW = CNT_W + NB + 1;
    his_state_e    state_q, state_d;
    logic          bank_q, rd_vld_q, full, empty, pop, accept;
    logic [NB:0]   rd_cnt_q, rd_addr_q;
    logic [1:0]    occ;
    logic [FW-1:0] head;
    assign accept    = state_q == IDLE && start;
    assign binValid  = !empty;
    assign pop       = binValid && binReady;
    assign occ       = full ? 2'd2 : {1'b0, !empty};
    // Credit the entry leaving this cycle so a streaming consumer sees 1 bin/cycle
    assign rdEn      = state_q == READ && !rd_cnt_q[NB] &&
                       (occ - {1'b0, pop} + {1'b0, rd_vld_q}) < 2'd2;
    assign rdAddr    = rdEn ? {bank_q, rd_cnt_q[NB-1:0]} : '0;
    assign clrEn     = rd_vld_q;
    assign clrAddr   = rd_addr_q;
    assign {binLast, binAddr, binData} = head;
    assign peakValid = state_q == DONE;
    assign busy      = state_q != IDLE;
    his_skid_fifo #(.W(FW)) u_fifo (
        .clk   (clk),
        .res   (res),
        .push  (rd_vld_q),
        .pop   (pop),
        .din   ({rd_addr_q[NB-1:0] == '1, rd_addr_q[NB-1:0], rdData}),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = start ? READ : IDLE;
            READ:    state_d = (rdEn && rd_cnt_q[NB-1:0] == '1) ? DRAIN : READ;
            DRAIN:   state_d = (pop && binLast) ? DONE : DRAIN;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state_q   <= IDLE;
            bank_q    <= 1'b0;
            rd_cnt_q  <= '0;
            rd_vld_q  <= 1'b0;
            rd_addr_q <= '0;
            peakAddr  <= '0;
            peakCount <= '0;
        end else begin
            state_q   <= state_d;
            rd_vld_q  <= rdEn;
            rd_addr_q <= rdAddr;
            if (accept) begin
                bank_q    <= hisNum;
                rd_cnt_q  <= '0;
                peakAddr  <= '0;
                peakCount <= '0;
            end else begin
                if (rdEn)
                    rd_cnt_q <= rd_cnt_q + (NB+1)'(1);
                // Strictly greater keeps the lowest index on ties
                if (pop && binData > peakCount) begin
                    peakAddr  <= binAddr;
                    peakCount <= binData;
                end
            end
        end
    end
endmodule

// File: tb/tb_his_reader_fsm.sv
// tb_his_reader_fsm: randomized self-checking bench for his_reader_fsm
module tb_his_reader_fsm;
    localparam int NB = 3, CNT_W = 16, BINS = 8;
    logic clk = 0, res = 0, start = 0, hisNum = 0, binReady = 0;
    logic rdEn, clrEn, binValid, binLast, peakValid, busy;
    logic [NB:0] rdAddr, clrAddr;
    logic [CNT_W-1:0] rdData = '0, binData, peakCount;
    logic [NB-1:0] binAddr, peakAddr;
    logic [63:0] all_out;
    int total = 0, bad = 0, cyc = 0, start_cyc = 0, rdy_mode = 0;
    int n_rd, n_xf, first_v, first_xf, last_xf;
    logic [CNT_W-1:0] mem [2*BINS];
    logic [CNT_W-1:0] exp_bins [BINS];
    int ref_bins [BINS] = '{5, 1, 9, 9, 0, 2, 7, 3};
    logic bank = 0, mon_on = 0, prev_stall = 0, prev_rden = 0, pe, rb;
    logic [NB:0] prev_rdaddr;
    logic [CNT_W-1:0] pd;
    logic [CNT_W+NB+1:0] prev_out;
    his_reader_fsm #(.NB(NB), .CNT_W(CNT_W)) dut (
        .clk(clk), .res(res), .start(start), .hisNum(hisNum),
        .rdEn(rdEn), .rdAddr(rdAddr), .rdData(rdData),
        .clrEn(clrEn), .clrAddr(clrAddr),
        .binValid(binValid), .binReady(binReady), .binData(binData),
        .binAddr(binAddr), .binLast(binLast),
        .peakValid(peakValid), .peakAddr(peakAddr), .peakCount(peakCount),
        .busy(busy)
    );
    assign all_out = 64'({rdEn, rdAddr, clrEn, clrAddr, binValid, binData, binAddr,
                          binLast, peakValid, peakAddr, peakCount, busy});
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask
    initial forever begin
        @(posedge clk);
        cyc++;
    end
    // Histogram memory: read data one cycle after rdEn, clrEn writes zero
    initial forever begin
        @(negedge clk);
        pe = rdEn;
        pd = mem[rdAddr];
        if (clrEn) mem[clrAddr] = '0;
        @(posedge clk);
        #1;
        rdData = pe ? pd : CNT_W'($urandom);
    end
    initial forever begin
        @(posedge clk);
        #1;
        case (rdy_mode)
            0: binReady = 1'b1;
            1: binReady = cyc[0];
            2: binReady = $urandom_range(0, 3) != 0;
            default: binReady = cyc > start_cyc + 10;
        endcase
    end
    always @(negedge clk) if (mon_on) begin
        check("clr_en", clrEn, prev_rden);
        if (clrEn) begin
            check("clr_addr", clrAddr, prev_rdaddr);
            check("clr_bank", clrAddr[NB], bank);
        end
        if (rdEn) begin
            check("rd_bank", rdAddr[NB], bank);
            check("rd_bin", rdAddr[NB-1:0], n_rd);
            n_rd++;
        end
        if (prev_stall) check("stall_hold", {binValid, binLast, binAddr, binData}, prev_out);
        if (binValid && first_v < 0) first_v = cyc - start_cyc;
        if (binValid && binReady) begin
            check("bin_addr", binAddr, n_xf);
            check("bin_data", binData, exp_bins[n_xf % BINS]);
            check("bin_last", binLast, n_xf == BINS - 1);
            if (n_xf == 0) first_xf = cyc;
            last_xf = cyc;
            n_xf++;
        end
        check("outstanding", (n_rd - n_xf) <= 2, 1);
        if (rdy_mode == 3 && cyc == start_cyc + 10) begin
            check("stall_reads", n_rd, 2);
            check("stall_addr", {binValid, binAddr}, {1'b1, 3'd0});
        end
        prev_stall  = binValid && !binReady;
        prev_out    = {binValid, binLast, binAddr, binData};
        prev_rden   = rdEn;
        prev_rdaddr = rdAddr;
    end
    task automatic arm(input logic b, input int mode);
        bank = b;
        for (int i = 0; i < BINS; i++) exp_bins[i] = mem[{b, NB'(i)}];
        n_rd = 0; n_xf = 0; first_v = -1; first_xf = 0; last_xf = 0;
        prev_stall = 0; prev_rden = 0; rdy_mode = mode;
        @(posedge clk);
        #1;
        start = 1; hisNum = b; start_cyc = cyc; mon_on = 1;
        @(posedge clk);
        #1;
        start = 0; hisNum = 1'($urandom);
    endtask
    task automatic readout(input logic b, input int mode, input bit inj);
        int pa;
        logic [CNT_W-1:0] pk;
        logic [BINS-1:0] cleared;
        bit got;
        arm(b, mode);
        pk = '0;
        for (int i = 0; i < BINS; i++) if (exp_bins[i] > pk) pk = exp_bins[i];
        pa = 0;
        for (int i = BINS - 1; i >= 0; i--) if (exp_bins[i] == pk) pa = i;
        if (inj) begin
            repeat (3) @(posedge clk);
            #1;
            start = 1; hisNum = ~b;
            @(posedge clk);
            #1;
            start = 0;
        end
        got = 0;
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge clk);
            got = peakValid;
        end
        check("peak_seen", got, 1);
        if (got) begin
            check("peak_addr", peakAddr, pa);
            check("peak_count", peakCount, pk);
            check("n_xfer", n_xf, BINS);
            check("n_read", n_rd, BINS);
            if (mode == 0) begin
                check("latency", first_v, 3);
                check("back2back", last_xf - first_xf, BINS - 1);
                check("peak_cyc", cyc - start_cyc, 11);
            end
            @(negedge clk);
            check("peak_pulse", {peakValid, busy}, 2'b00);
            check("peak_hold", {peakAddr, peakCount}, {pa[NB-1:0], pk});
            for (int i = 0; i < BINS; i++) cleared[i] = mem[{b, NB'(i)}] == '0;
            check("cleared", cleared, {BINS{1'b1}});
        end
        mon_on = 0;
    endtask
    initial begin
        for (int i = 0; i < 2 * BINS; i++) mem[i] = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out", all_out, 0);
        res = 1;
        for (int i = 0; i < BINS; i++) mem[i] = CNT_W'(ref_bins[i]);
        readout(0, 0, 0);
        for (int i = 0; i < BINS; i++) mem[i] = CNT_W'(ref_bins[i]);
        readout(0, 1, 0);
        for (int i = 0; i < BINS; i++) mem[i] = CNT_W'(ref_bins[i]);
        readout(0, 3, 0);
        for (int i = 0; i < BINS; i++) mem[BINS + i] = CNT_W'($urandom);
        readout(1, 2, 1);
        for (int i = 0; i < BINS; i++) mem[i] = CNT_W'($urandom_range(1, 1000));
        arm(0, 0);
        for (int i = 0; i < 100 && n_xf < 4; i++) @(negedge clk);
        check("xfer_before_rst", n_xf, 4);
        mon_on = 0;
        #2 res = 0;
        #1 check("rst_mid", all_out, 0);
        @(posedge clk);
        #1 check("rst_hold", all_out, 0);
        res = 1;
        readout(0, 0, 0);
        for (int i = 0; i < BINS; i++) mem[i] = '0;
        readout(0, 0, 0);
        readout(0, 2, 0);
        repeat (6) begin
            rb = 1'($urandom);
            for (int i = 0; i < BINS; i++)
                mem[{rb, NB'(i)}] = $urandom_range(0, 1) ? CNT_W'($urandom_range(0, 3)) : CNT_W'($urandom);
            readout(rb, $urandom_range(0, 2), 1'($urandom_range(0, 1)));
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
